// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified-memory port arbiter: owner, FSM state and access-size codes.
package riscv_mem_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] F3_FETCH = F3_W;

endpackage

// File: rtl/mem_arb_pick.sv
// Data-priority arbiter with a starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic [1:0] excl,
    input  logic       issue,
    output logic       gnt_i,
    output logic       gnt_d
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          req_i, req_d, starved;

    always_comb begin
        gnt_i        = 1'b0;
        gnt_d        = 1'b0;
        starve_cnt_d = starve_cnt_q;
        req_i        = i_req & ~excl[OWN_I];
        req_d        = d_req & ~excl[OWN_D];
        starved      = (starve_cnt_q == SW'(STARVE_MAX));

        if (issue) begin
            if (req_d && !(req_i && starved)) begin
                gnt_d = 1'b1;
            end else if (req_i) begin
                gnt_i = 1'b1;
            end

            // Count only data grants that actually made a fetch wait; saturate at the limit.
            if (gnt_i) begin
                starve_cnt_d = '0;
            end else if (gnt_d && req_i && !starved) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data-port accesses onto one single-port memory with fixed-latency completion.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            we_q, we_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;

    logic            done, issue, gnt_i, gnt_d;
    logic [1:0]      excl;

    // Completion frees the port in the same cycle; issue is held off while reset is asserted.
    always_comb begin
        done        = (state_q == ST_WAIT) && (lat_cnt_q == '0);
        issue       = rst && ((state_q == ST_IDLE) || done);
        excl        = '0;
        excl[OWN_I] = done && (owner_q == OWN_I);
        excl[OWN_D] = done && (owner_q == OWN_D);
    end

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .i_req (i_req),
        .d_req (d_req),
        .excl  (excl),
        .issue (issue),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lat_cnt_d  = lat_cnt_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;

        if ((state_q == ST_WAIT) && (lat_cnt_q != '0)) begin
            lat_cnt_d = lat_cnt_q - LW'(1);
        end

        if (done) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_I) begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = we_q ? '0 : mem_rdata;
            end
        end

        if (gnt_i || gnt_d) begin
            mem_en    = 1'b1;
            state_d   = ST_WAIT;
            lat_cnt_d = LW'(MEM_LAT - 1);
            if (gnt_d) begin
                owner_d    = OWN_D;
                we_d       = d_we;
                mem_we     = d_we;
                mem_funct3 = d_funct3;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
            end else begin
                owner_d    = OWN_I;
                we_d       = 1'b0;
                mem_funct3 = F3_FETCH;
                mem_addr   = i_addr;
            end
        end

        i_stall = i_req & ~i_rvalid;
        d_stall = d_req & ~d_rvalid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1/2/3) each backed by a small word memory model.
module tb_mem_port_arbiter;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst, i_req, i_rvalid, i_stall, d_req, d_we, d_rvalid, d_stall, mem_en, mem_we;
    logic [N-1:0][2:0]  d_funct3, mem_funct3;
    logic [N-1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    // Instance g uses MEM_LAT = g+1; the memory word at byte address a initially holds 0x1000_0000 + a.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        initial for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + 32'(k * 4);

        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
            pipe[0] <= mem_en[g] ? mem[mem_addr[g][9:2]] : 32'hBAD0_BAD0;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        assign mem_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .MEM_LAT    (LAT),
            .STARVE_MAX (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .i_req      (i_req[g]),
            .i_addr     (i_addr[g]),
            .i_rdata    (i_rdata[g]),
            .i_rvalid   (i_rvalid[g]),
            .i_stall    (i_stall[g]),
            .d_req      (d_req[g]),
            .d_we       (d_we[g]),
            .d_funct3   (d_funct3[g]),
            .d_addr     (d_addr[g]),
            .d_wdata    (d_wdata[g]),
            .d_rdata    (d_rdata[g]),
            .d_rvalid   (d_rvalid[g]),
            .d_stall    (d_stall[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_funct3 (mem_funct3[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nxt();
        i_req = 3'b001;
        d_req = 3'b010;
        i_addr[0] = 32'h0;
        d_addr[1] = 32'h100;
        @(negedge clk);
        total++; if (mem_en !== 3'b000) begin bad++; $display("FAIL rst_mem_en: got %b want 000", mem_en); end
        total++; if (i_stall !== 3'b001) begin bad++; $display("FAIL rst_i_stall: got %b want 001", i_stall); end
        total++; if (d_stall !== 3'b010) begin bad++; $display("FAIL rst_d_stall: got %b want 010", d_stall); end
        total++; if ({i_rvalid, d_rvalid} !== 6'b0) begin bad++; $display("FAIL rst_rvalid: got %b/%b want 0", i_rvalid, d_rvalid); end
        total++; if (i_rdata[0] !== 32'h0 || d_rdata[1] !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h/%h want 0", i_rdata[0], d_rdata[1]); end
        nxt();
        i_req = '0;
        d_req = '0;
        rst   = '1;
        @(negedge clk);
        total++; if (mem_en !== 3'b000) begin bad++; $display("FAIL rst_release_idle: got %b want 000", mem_en); end
        nxt();
    endtask

    // Fetch-only on MEM_LAT=1: the held request completes, then the next PC issues the following cycle.
    task automatic test_fetch_stream();
        logic [31:0] pc;
        i_req[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pc = 32'(k * 4);
            i_addr[0] = pc;
            @(negedge clk);
            total++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== pc || mem_funct3[0] !== 3'b010 || mem_we[0] !== 1'b0)
                begin bad++; $display("FAIL fetch_issue%0d: got en=%b a=%h f3=%b we=%b want en=1 a=%h f3=010 we=0", k, mem_en[0], mem_addr[0], mem_funct3[0], mem_we[0], pc); end
            total++; if (i_rvalid[0] !== 1'b0 || i_stall[0] !== 1'b1) begin bad++; $display("FAIL fetch_wait%0d: got rv=%b st=%b want rv=0 st=1", k, i_rvalid[0], i_stall[0]); end
            nxt();
            @(negedge clk);
            total++; if (i_rvalid[0] !== 1'b1 || i_rdata[0] !== 32'h1000_0000 + pc || i_stall[0] !== 1'b0)
                begin bad++; $display("FAIL fetch_done%0d: got rv=%b d=%h st=%b want rv=1 d=%h st=0", k, i_rvalid[0], i_rdata[0], i_stall[0], 32'h1000_0000 + pc); end
            total++; if (mem_en[0] !== 1'b0) begin bad++; $display("FAIL fetch_noreissue%0d: got %b want 0", k, mem_en[0]); end
            nxt();
        end
        i_req[0] = 1'b0;
        @(negedge clk);
        total++; if (mem_en[0] !== 1'b0 || i_rvalid[0] !== 1'b0) begin bad++; $display("FAIL fetch_idle: got en=%b rv=%b want 0 0", mem_en[0], i_rvalid[0]); end
        nxt();
    endtask

    // Simultaneous requests on MEM_LAT=2: data first, fetch issued in the data completion cycle.
    task automatic test_simultaneous();
        i_req[1] = 1'b1; i_addr[1] = 32'h20;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h100; d_funct3[1] = 3'b010; d_wdata[1] = 32'h0;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h100 || mem_we[1] !== 1'b0)
            begin bad++; $display("FAIL simul_d_issue: got en=%b a=%h we=%b want 1 00000100 0", mem_en[1], mem_addr[1], mem_we[1]); end
        total++; if (i_stall[1] !== 1'b1 || d_stall[1] !== 1'b1) begin bad++; $display("FAIL simul_stall_c0: got i=%b d=%b want 1 1", i_stall[1], d_stall[1]); end
        nxt();
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b0 || d_rvalid[1] !== 1'b0 || i_stall[1] !== 1'b1)
            begin bad++; $display("FAIL simul_c1: got en=%b drv=%b ist=%b want 0 0 1", mem_en[1], d_rvalid[1], i_stall[1]); end
        nxt();
        @(negedge clk);
        total++; if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'h1000_0100 || d_stall[1] !== 1'b0)
            begin bad++; $display("FAIL simul_d_done: got rv=%b d=%h st=%b want 1 10000100 0", d_rvalid[1], d_rdata[1], d_stall[1]); end
        total++; if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h20 || mem_funct3[1] !== 3'b010 || i_stall[1] !== 1'b1)
            begin bad++; $display("FAIL simul_i_issue: got en=%b a=%h f3=%b ist=%b want 1 00000020 010 1", mem_en[1], mem_addr[1], mem_funct3[1], i_stall[1]); end
        nxt();
        d_req[1] = 1'b0;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b0 || i_stall[1] !== 1'b1 || i_rvalid[1] !== 1'b0)
            begin bad++; $display("FAIL simul_c3: got en=%b ist=%b irv=%b want 0 1 0", mem_en[1], i_stall[1], i_rvalid[1]); end
        nxt();
        @(negedge clk);
        total++; if (i_rvalid[1] !== 1'b1 || i_rdata[1] !== 32'h1000_0020 || i_stall[1] !== 1'b0)
            begin bad++; $display("FAIL simul_i_done: got rv=%b d=%h st=%b want 1 10000020 0", i_rvalid[1], i_rdata[1], i_stall[1]); end
        nxt();
        i_req[1] = 1'b0;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b0) begin bad++; $display("FAIL simul_idle: got %b want 0", mem_en[1]); end
        nxt();
    endtask

    // Both ports request from IDLE each round; the fetch is withdrawn whenever data wins.
    task automatic test_starve();
        logic [9:0]  exp_i;
        logic [31:0] want_a, got_d;
        logic [2:0]  want_f3;
        exp_i = 10'b10_0001_0000;
        d_we[0] = 1'b0; d_funct3[0] = 3'b100; i_addr[0] = 32'h300;
        for (int r = 0; r < 10; r++) begin
            i_req[0] = 1'b1; d_req[0] = 1'b1; d_addr[0] = 32'h200 + 32'(4 * r);
            want_a  = exp_i[r] ? 32'h300 : 32'h200 + 32'(4 * r);
            want_f3 = exp_i[r] ? 3'b010 : 3'b100;
            @(negedge clk);
            total++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== want_a || mem_funct3[0] !== want_f3)
                begin bad++; $display("FAIL starve_grant%0d: got en=%b a=%h f3=%b want 1 %h %b", r, mem_en[0], mem_addr[0], mem_funct3[0], want_a, want_f3); end
            nxt();
            i_req[0] = 1'b0; d_req[0] = 1'b0;
            @(negedge clk);
            got_d = exp_i[r] ? i_rdata[0] : d_rdata[0];
            total++; if ({i_rvalid[0], d_rvalid[0]} !== (exp_i[r] ? 2'b10 : 2'b01) || got_d !== 32'h1000_0000 + want_a)
                begin bad++; $display("FAIL starve_done%0d: got irv=%b drv=%b d=%h want owner_i=%b d=%h", r, i_rvalid[0], d_rvalid[0], got_d, exp_i[r], 32'h1000_0000 + want_a); end
            nxt();
        end
    endtask

    // Store then load of the same word on MEM_LAT=2; store data changes after issue must be ignored.
    task automatic test_store_load();
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_funct3[1] = 3'b010; d_addr[1] = 32'h40; d_wdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b1 || mem_addr[1] !== 32'h40 || mem_wdata[1] !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL store_issue: got en=%b we=%b a=%h wd=%h want 1 1 00000040 deadbeef", mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1]); end
        nxt();
        d_wdata[1] = 32'h1234_5678;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b0 || mem_we[1] !== 1'b0) begin bad++; $display("FAIL store_c1: got en=%b we=%b want 0 0", mem_en[1], mem_we[1]); end
        nxt();
        @(negedge clk);
        total++; if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'h0 || mem_en[1] !== 1'b0)
            begin bad++; $display("FAIL store_ack: got rv=%b d=%h en=%b want 1 00000000 0", d_rvalid[1], d_rdata[1], mem_en[1]); end
        nxt();
        d_we[1] = 1'b0; d_wdata[1] = 32'h0;
        @(negedge clk);
        total++; if (mem_en[1] !== 1'b1 || mem_we[1] !== 1'b0 || mem_wdata[1] !== 32'h0 || mem_addr[1] !== 32'h40)
            begin bad++; $display("FAIL load_issue: got en=%b we=%b wd=%h a=%h want 1 0 0 00000040", mem_en[1], mem_we[1], mem_wdata[1], mem_addr[1]); end
        nxt();
        nxt();
        @(negedge clk);
        total++; if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL load_data: got rv=%b d=%h want 1 deadbeef", d_rvalid[1], d_rdata[1]); end
        nxt();
        d_req[1] = 1'b0;
    endtask

    // Fetch withdrawn right after issue on MEM_LAT=3: completion still pulses, no second access.
    task automatic test_drop();
        i_req[2] = 1'b1; i_addr[2] = 32'h80;
        @(negedge clk);
        total++; if (mem_en[2] !== 1'b1 || mem_addr[2] !== 32'h80) begin bad++; $display("FAIL drop_issue: got en=%b a=%h want 1 00000080", mem_en[2], mem_addr[2]); end
        nxt();
        i_req[2] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            total++; if (mem_en[2] !== 1'b0 || i_rvalid[2] !== (c == 3) || i_stall[2] !== 1'b0)
                begin bad++; $display("FAIL drop_c%0d: got en=%b rv=%b st=%b want 0 %b 0", c, mem_en[2], i_rvalid[2], i_stall[2], (c == 3)); end
            if (c == 3) begin
                total++; if (i_rdata[2] !== 32'h1000_0080) begin bad++; $display("FAIL drop_data: got %h want 10000080", i_rdata[2]); end
            end
            nxt();
        end
    endtask

    // Reset pulse during a MEM_LAT=3 load discards it; the next request issues cleanly from IDLE.
    task automatic test_rst_mid();
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_funct3[2] = 3'b010; d_addr[2] = 32'h10;
        @(negedge clk);
        total++; if (mem_en[2] !== 1'b1) begin bad++; $display("FAIL rstmid_issue: got %b want 1", mem_en[2]); end
        nxt();
        rst[2] = 1'b0;
        @(negedge clk);
        total++; if (mem_en[2] !== 1'b0 || d_rvalid[2] !== 1'b0 || d_stall[2] !== 1'b1)
            begin bad++; $display("FAIL rstmid_in_reset: got en=%b rv=%b st=%b want 0 0 1", mem_en[2], d_rvalid[2], d_stall[2]); end
        nxt();
        rst[2] = 1'b1; d_req[2] = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++; if (mem_en[2] !== 1'b0 || d_rvalid[2] !== 1'b0) begin bad++; $display("FAIL rstmid_c%0d: got en=%b rv=%b want 0 0", c, mem_en[2], d_rvalid[2]); end
            nxt();
        end
        d_req[2] = 1'b1; d_addr[2] = 32'h14;
        @(negedge clk);
        total++; if (mem_en[2] !== 1'b1 || mem_addr[2] !== 32'h14) begin bad++; $display("FAIL rstmid_reissue: got en=%b a=%h want 1 00000014", mem_en[2], mem_addr[2]); end
        nxt();
        nxt();
        nxt();
        @(negedge clk);
        total++; if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== 32'h1000_0014) begin bad++; $display("FAIL rstmid_done: got rv=%b d=%h want 1 10000014", d_rvalid[2], d_rdata[2]); end
        nxt();
        d_req[2] = 1'b0;
    endtask

    initial begin
        rst = '1;
        i_req = '0; d_req = '0; d_we = '0; d_funct3 = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #2;
        rst = '0;
        test_reset();
        test_fetch_stream();
        test_simultaneous();
        test_starve();
        test_store_load();
        test_drop();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
